// File: rtl/rv32i_types.sv
// Shared RV32I types used across the cache hierarchy, including the
// arbitration policy and FSM state encodings for the memory arbiter.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic {
        ARB_FIXED,
        ARB_ROUND_ROBIN
    } arb_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner search: scans the request vector starting at
// last_grant+1 (round robin) or at port 0 (fixed priority).
module rr_picker
    import rv32i_types::*;
#(
    parameter int NUM_PORTS = 2,
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    input  arb_mode_t            mode,
    output logic [IDX_W-1:0]     grant,
    output logic                 valid
);

    always_comb begin : pick
        int start;
        int cand;
        logic [IDX_W-1:0] idx;
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        start = (mode == ARB_FIXED) ? 0 : ((int'(last_grant) + 1) % NUM_PORTS);
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = (start + k) % NUM_PORTS;
            idx  = IDX_W'(cand);
            // First hit in scan order wins; later hits are ignored.
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Multi-port physical-memory arbiter: grants one cache-side line request at a
// time, holds it on the pmem bus until completion or timeout, then pulses req_resp.
module pmem_arbiter
    import rv32i_types::*;
#(
    parameter int        NUM_PORTS      = 2,
    parameter int        LINE_WIDTH     = 256,
    parameter arb_mode_t MODE           = ARB_ROUND_ROBIN,
    parameter int        TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_PORTS-1:0]                 req_read,
    input  logic [NUM_PORTS-1:0]                 req_write,
    input  rv32i_word [NUM_PORTS-1:0]            req_address,
    input  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]                 req_resp,
    output logic [NUM_PORTS-1:0]                 req_error,
    output logic [LINE_WIDTH-1:0]                req_rdata,
    output logic                                 pmem_read,
    output logic                                 pmem_write,
    output rv32i_word                            pmem_address,
    output logic [LINE_WIDTH-1:0]                pmem_wdata,
    input  logic                                 pmem_resp,
    input  logic                                 pmem_error,
    input  logic [LINE_WIDTH-1:0]                pmem_rdata
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t              state, state_next;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_valid;
    logic [IDX_W-1:0]        grant_q;
    logic [IDX_W-1:0]        last_grant;
    rv32i_word               addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q;
    logic                    write_q;
    logic [LINE_WIDTH-1:0]   rdata_q;
    logic                    error_q;
    logic [CNT_W-1:0]        tcount;
    logic                    timeout_hit;

    rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
        .req        (req_read | req_write),
        .last_grant (last_grant),
        .mode       (MODE),
        .grant      (pick_idx),
        .valid      (pick_valid)
    );

    // A response on the final cycle wins over the timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !pmem_resp && (tcount == T_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = BUSY;
            BUSY:    if (pmem_resp || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q    <= '0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            rdata_q    <= '0;
            error_q    <= 1'b0;
            tcount     <= '0;
        end else begin
            case (state)
                IDLE: if (pick_valid) begin
                    grant_q    <= pick_idx;
                    last_grant <= pick_idx;
                    addr_q     <= req_address[pick_idx];
                    wdata_q    <= req_wdata[pick_idx];
                    write_q    <= req_write[pick_idx];
                    tcount     <= '0;
                end
                BUSY: begin
                    if (pmem_resp) begin
                        rdata_q <= pmem_rdata;
                        error_q <= pmem_error;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        error_q <= 1'b1;
                    end else begin
                        tcount <= tcount + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pmem_read    = (state == BUSY) && !write_q;
    assign pmem_write   = (state == BUSY) && write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign req_rdata    = rdata_q;

    always_comb begin
        req_resp  = '0;
        req_error = '0;
        if (state == DONE) begin
            req_resp[grant_q]  = 1'b1;
            req_error[grant_q] = error_q;
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a round-robin and a fixed-priority instance
// (4 ports, 16-cycle timeout) sharing the memory-side inputs.
module tb_pmem_arbiter;
    import rv32i_types::*;

    localparam int N  = 4;
    localparam int LW = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]         rr_req_read, rr_req_write, rr_req_resp, rr_req_error;
    rv32i_word [N-1:0]    rr_req_address;
    logic [N-1:0][LW-1:0] rr_req_wdata;
    logic [LW-1:0]        rr_req_rdata, rr_pmem_wdata;
    logic                 rr_pmem_read, rr_pmem_write;
    rv32i_word            rr_pmem_address;

    logic [N-1:0]         fx_req_read, fx_req_write, fx_req_resp, fx_req_error;
    rv32i_word [N-1:0]    fx_req_address;
    logic [N-1:0][LW-1:0] fx_req_wdata;
    logic [LW-1:0]        fx_req_rdata, fx_pmem_wdata;
    logic                 fx_pmem_read, fx_pmem_write;
    rv32i_word            fx_pmem_address;

    logic                 pmem_resp, pmem_error;
    logic [LW-1:0]        pmem_rdata;

    int errors = 0;
    int checks = 0;

    pmem_arbiter #(.NUM_PORTS(N), .LINE_WIDTH(LW), .MODE(ARB_ROUND_ROBIN), .TIMEOUT_CYCLES(16)) dut_rr (
        .clk(clk), .rst(rst),
        .req_read(rr_req_read), .req_write(rr_req_write), .req_address(rr_req_address),
        .req_wdata(rr_req_wdata), .req_resp(rr_req_resp), .req_error(rr_req_error),
        .req_rdata(rr_req_rdata), .pmem_read(rr_pmem_read), .pmem_write(rr_pmem_write),
        .pmem_address(rr_pmem_address), .pmem_wdata(rr_pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_error(pmem_error), .pmem_rdata(pmem_rdata)
    );

    pmem_arbiter #(.NUM_PORTS(N), .LINE_WIDTH(LW), .MODE(ARB_FIXED), .TIMEOUT_CYCLES(16)) dut_fx (
        .clk(clk), .rst(rst),
        .req_read(fx_req_read), .req_write(fx_req_write), .req_address(fx_req_address),
        .req_wdata(fx_req_wdata), .req_resp(fx_req_resp), .req_error(fx_req_error),
        .req_rdata(fx_req_rdata), .pmem_read(fx_pmem_read), .pmem_write(fx_pmem_write),
        .pmem_address(fx_pmem_address), .pmem_wdata(fx_pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_error(pmem_error), .pmem_rdata(pmem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit strobe(input bit sel);
        return sel ? (fx_pmem_read | fx_pmem_write) : (rr_pmem_read | rr_pmem_write);
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Memory-side driver: waits for a strobe, answers on the lat-th strobe cycle
    // (lat=0 never answers), returns what the requester side shows in DONE.
    task automatic serve(input bit sel, input int lat, input logic err, input logic [LW-1:0] data,
                         output int hi, output logic [N-1:0] resp_v, output logic [N-1:0] err_v,
                         output logic [LW-1:0] rdata, output bit ok);
        int waitc;
        hi = 0; ok = 1'b0; resp_v = '0; err_v = '0; rdata = '0; waitc = 0;
        while (!strobe(sel) && waitc < 20) begin tick(); waitc++; end
        if (!strobe(sel)) return;
        while (strobe(sel) && hi < 40) begin
            hi++;
            if (hi == lat) begin pmem_resp = 1'b1; pmem_error = err; pmem_rdata = data; end
            tick();
            pmem_resp = 1'b0; pmem_error = 1'b0;
        end
        if (strobe(sel)) return;
        resp_v = sel ? fx_req_resp : rr_req_resp;
        err_v  = sel ? fx_req_error : rr_req_error;
        rdata  = sel ? fx_req_rdata : rr_req_rdata;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (rr_req_resp !== 4'b0 || rr_req_error !== 4'b0) begin errors++;
            $display("FAIL reset_resp: got resp=%b err=%b expected 0000/0000", rr_req_resp, rr_req_error); end
        checks++; if ({rr_pmem_read, rr_pmem_write, fx_pmem_read, fx_pmem_write} !== 4'b0) begin errors++;
            $display("FAIL reset_strobes: got %b expected 0000", {rr_pmem_read, rr_pmem_write, fx_pmem_read, fx_pmem_write}); end
        checks++; if (rr_pmem_address !== 32'h0 || rr_pmem_wdata !== '0 || rr_req_rdata !== '0) begin errors++;
            $display("FAIL reset_data: got addr=%h wdata/rdata nonzero expected all zero", rr_pmem_address); end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (rr_pmem_read !== 1'b0) begin errors++;
            $display("FAIL idle_no_req: got pmem_read=%b expected 0", rr_pmem_read); end
    endtask

    task automatic test_rr_contention();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int hi, g; logic [N-1:0] rv, ev; logic [LW-1:0] rd; bit ok;
        for (int i = 0; i < N; i++) rr_req_address[i] = 32'h100 * (i + 1);
        rr_req_read = 4'hF;
        for (int n = 0; n < 5; n++) begin
            serve(1'b0, 2, 1'b0, {8{32'(n)}}, hi, rv, ev, rd, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_serve_%0d: got no completion expected completion", n); end
            g = onehot_idx(rv);
            checks++; if (g != exp_order[n]) begin errors++;
                $display("FAIL rr_order_%0d: got resp=%b expected port %0d", n, rv, exp_order[n]); end
            if (n == 4 || g < 0) begin
                rr_req_read = '0;
                tick(); tick();
            end else begin
                rr_req_read[g] = 1'b0;
                tick(); tick();
                rr_req_read[g] = 1'b1;
            end
        end
        tick();
    endtask

    task automatic test_fixed();
        int exp_order[3] = '{0, 1, 0};
        int hi, g; logic [N-1:0] rv, ev; logic [LW-1:0] rd; bit ok;
        for (int i = 0; i < N; i++) fx_req_address[i] = 32'h200 * (i + 1);
        fx_req_read = 4'hF;
        for (int n = 0; n < 3; n++) begin
            serve(1'b1, 2, 1'b0, '0, hi, rv, ev, rd, ok);
            checks++; if (!ok) begin errors++; $display("FAIL fx_serve_%0d: got no completion expected completion", n); end
            g = onehot_idx(rv);
            checks++; if (g != exp_order[n]) begin errors++;
                $display("FAIL fx_order_%0d: got resp=%b expected port %0d", n, rv, exp_order[n]); end
            if (n == 2 || g < 0) begin
                fx_req_read = '0;
                tick(); tick();
            end else begin
                fx_req_read[g] = 1'b0;
                tick(); tick();
                fx_req_read[g] = 1'b1;
            end
        end
        tick();
    endtask

    task automatic test_single_read();
        int hi; logic [N-1:0] rv, ev; logic [LW-1:0] rd, a5; bit ok;
        a5 = {32{8'hA5}};
        rr_req_address[0] = 32'h0000_1000;
        rr_req_read = 4'b0001;
        tick();
        checks++; if (rr_pmem_read !== 1'b1 || rr_pmem_write !== 1'b0 || rr_pmem_address !== 32'h0000_1000) begin errors++;
            $display("FAIL read_issue: got rd=%b wr=%b addr=%h expected 1 0 00001000", rr_pmem_read, rr_pmem_write, rr_pmem_address); end
        serve(1'b0, 5, 1'b0, a5, hi, rv, ev, rd, ok);
        checks++; if (!ok || hi != 5) begin errors++; $display("FAIL read_strobe_len: got %0d cycles expected 5", hi); end
        checks++; if (rv !== 4'b0001 || ev !== 4'b0000) begin errors++;
            $display("FAIL read_resp: got resp=%b err=%b expected 0001/0000", rv, ev); end
        checks++; if (rd !== a5) begin errors++; $display("FAIL read_data: got %h expected %h", rd, a5); end
        rr_req_read = '0;
        tick();
        checks++; if (rr_req_resp !== 4'b0 || rr_req_rdata !== a5) begin errors++;
            $display("FAIL read_after_done: got resp=%b rdata=%h expected 0000 held data", rr_req_resp, rr_req_rdata); end
        tick();
        checks++; if (rr_pmem_read !== 1'b0) begin errors++; $display("FAIL read_no_dup: got pmem_read=%b expected 0", rr_pmem_read); end
    endtask

    task automatic test_write_error();
        int hi; logic [N-1:0] rv, ev; logic [LW-1:0] rd, w1; bit ok;
        w1 = {8{32'hDEAD_BEEF}};
        rr_req_wdata[0] = {8{32'h1234_5678}};
        rr_req_wdata[1] = w1;
        rr_req_address[1] = 32'h0000_2000;
        rr_req_write = 4'b0010;
        tick();
        checks++; if (rr_pmem_write !== 1'b1 || rr_pmem_read !== 1'b0 || rr_pmem_address !== 32'h0000_2000) begin errors++;
            $display("FAIL write_issue: got wr=%b rd=%b addr=%h expected 1 0 00002000", rr_pmem_write, rr_pmem_read, rr_pmem_address); end
        checks++; if (rr_pmem_wdata !== w1) begin errors++; $display("FAIL write_data: got %h expected %h", rr_pmem_wdata, w1); end
        serve(1'b0, 3, 1'b1, '0, hi, rv, ev, rd, ok);
        checks++; if (!ok || rv !== 4'b0010 || ev !== 4'b0010) begin errors++;
            $display("FAIL write_err_resp: got resp=%b err=%b expected 0010/0010", rv, ev); end
        rr_req_write = '0;
        tick(); tick();
    endtask

    task automatic test_timeout();
        int hi; logic [N-1:0] rv, ev; logic [LW-1:0] rd; bit ok;
        rr_req_address[0] = 32'h0000_4000;
        rr_req_read = 4'b0001;
        serve(1'b0, 0, 1'b0, '0, hi, rv, ev, rd, ok);
        checks++; if (!ok || hi != 16) begin errors++; $display("FAIL timeout_len: got %0d cycles expected 16", hi); end
        checks++; if (rv !== 4'b0001 || ev !== 4'b0001 || rd !== '0) begin errors++;
            $display("FAIL timeout_resp: got resp=%b err=%b rdata=%h expected 0001/0001/0", rv, ev, rd); end
        rr_req_read = '0;
        tick();
        checks++; if (rr_req_resp !== 4'b0 || rr_req_error !== 4'b0 || strobe(1'b0) !== 1'b0) begin errors++;
            $display("FAIL timeout_idle: got resp=%b err=%b expected 0000/0000 no strobe", rr_req_resp, rr_req_error); end
        tick();
    endtask

    task automatic test_read_write_same_port();
        int hi; logic [N-1:0] rv, ev; logic [LW-1:0] rd, w3; bit ok;
        w3 = {8{32'hC0FF_EE03}};
        rr_req_wdata[3] = w3;
        rr_req_address[3] = 32'h0000_3000;
        rr_req_read = 4'b1000;
        rr_req_write = 4'b1000;
        tick();
        checks++; if (rr_pmem_write !== 1'b1 || rr_pmem_read !== 1'b0 || rr_pmem_wdata !== w3) begin errors++;
            $display("FAIL rw_is_write: got wr=%b rd=%b expected 1 0 with port-3 data", rr_pmem_write, rr_pmem_read); end
        serve(1'b0, 2, 1'b0, '0, hi, rv, ev, rd, ok);
        checks++; if (!ok || rv !== 4'b1000 || ev !== 4'b0000) begin errors++;
            $display("FAIL rw_resp: got resp=%b err=%b expected 1000/0000", rv, ev); end
        rr_req_read = '0;
        rr_req_write = '0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_busy();
        int hi; logic [N-1:0] rv, ev, seen; logic [LW-1:0] rd; bit ok;
        rr_req_address[2] = 32'h0000_5000;
        rr_req_read = 4'b0100;
        tick();
        checks++; if (rr_pmem_read !== 1'b1 || rr_pmem_address !== 32'h0000_5000) begin errors++;
            $display("FAIL rst_busy_start: got rd=%b addr=%h expected 1 00005000", rr_pmem_read, rr_pmem_address); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (rr_pmem_read !== 1'b0 || rr_pmem_address !== 32'h0 || rr_req_resp !== 4'b0) begin errors++;
            $display("FAIL rst_async: got rd=%b addr=%h resp=%b expected 0 0 0000", rr_pmem_read, rr_pmem_address, rr_req_resp); end
        tick();
        rst = 1'b0;
        rr_req_read = '0;
        tick();
        pmem_resp = 1'b1; pmem_rdata = {8{32'hFFFF_FFFF}};
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pmem_resp = 1'b0;
            seen = seen | rr_req_resp | {3'b0, rr_pmem_read};
        end
        checks++; if (seen !== 4'b0 || rr_req_rdata !== '0) begin errors++;
            $display("FAIL rst_late_resp: got activity=%b rdata=%h expected none", seen, rr_req_rdata); end
        rr_req_read = 4'b1001;
        serve(1'b0, 2, 1'b0, '0, hi, rv, ev, rd, ok);
        checks++; if (!ok || rv !== 4'b0001) begin errors++;
            $display("FAIL rst_next_grant: got resp=%b expected 0001", rv); end
        rr_req_read = '0;
        tick(); tick();
    endtask

    initial begin
        rr_req_read = '0; rr_req_write = '0; rr_req_address = '0; rr_req_wdata = '0;
        fx_req_read = '0; fx_req_write = '0; fx_req_address = '0; fx_req_wdata = '0;
        pmem_resp = 1'b0; pmem_error = 1'b0; pmem_rdata = '0;
        test_reset();
        test_rr_contention();
        test_fixed();
        test_single_read();
        test_write_error();
        test_timeout();
        test_read_write_same_port();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 expected finish");
        $fatal(1, "watchdog");
    end

endmodule
